// File: rtl/a2d_scheduler.sv
// Round-robin ADC128S conversion scheduler for channels 0, 4 and 5.
// Each conversion is a command transaction followed by a read transaction.
module a2d_scheduler #(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy
);

  localparam int W = SCLK_DIV_W;
  localparam logic [W-1:0] DIV_LD  = {2'b10, {(W-2){1'b1}}};
  localparam logic [W-1:0] DIV_SMP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] DIV_END = '1;
  localparam logic [W-1:0] DIV_SHF = '0;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP,
    READ,
    DONE
  } state_t;

  state_t       state;
  logic [1:0]   ptr;
  logic [W-1:0] div;
  logic [4:0]   cnt;
  logic [15:0]  tx;
  logic [11:0]  rx;
  logic         gap;
  logic [2:0]   ch;
  logic         xfer_end;

  assign SCLK = div[W-1];
  assign MOSI = tx[15];
  assign xfer_end = !SS_n && (div == DIV_END) && (cnt == 5'd16);

  always_comb begin
    ch = 3'd0;
    unique case (ptr)
      2'd1:    ch = 3'd4;
      2'd2:    ch = 3'd5;
      default: ch = 3'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      div       <= DIV_END;
      cnt       <= 5'd0;
      tx        <= 16'h0000;
      rx        <= 12'h000;
      gap       <= 1'b0;
      SS_n      <= 1'b1;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      batt      <= 12'h000;
      cnv_cmplt <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnv_cmplt <= 1'b0;
      // Sample just before SCLK rises; shift MOSI one clk after it falls,
      // skipping the leading fall so bit 15 is seen by the first rise.
      if (!SS_n) begin
        div <= div + 1'b1;
        if (div == DIV_SMP) begin
          rx  <= {rx[10:0], MISO};
          cnt <= cnt + 1'b1;
        end
        if (div == DIV_SHF && cnt != 5'd0)
          tx <= {tx[14:0], 1'b0};
      end
      unique case (state)
        IDLE: begin
          if (nxt) begin
            SS_n  <= 1'b0;
            div   <= DIV_LD;
            cnt   <= 5'd0;
            tx    <= {2'b00, ch, 11'h000};
            busy  <= 1'b1;
            state <= CMD;
          end
        end
        CMD: begin
          if (xfer_end) begin
            SS_n  <= 1'b1;
            div   <= DIV_END;
            tx    <= 16'h0000;
            gap   <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          if (gap) begin
            SS_n  <= 1'b0;
            div   <= DIV_LD;
            cnt   <= 5'd0;
            tx    <= 16'h0000;
            state <= READ;
          end else begin
            gap <= 1'b1;
          end
        end
        READ: begin
          if (xfer_end) begin
            SS_n      <= 1'b1;
            div       <= DIV_END;
            tx        <= 16'h0000;
            cnv_cmplt <= 1'b1;
            unique case (ptr)
              2'd1:    rght_ld <= rx;
              2'd2:    batt    <= rx;
              default: lft_ld  <= rx;
            endcase
            ptr   <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_scheduler.sv
// Bench for a2d_scheduler: ADC128S bus model, SPI timing monitor and
// cycle-level conversion model compared every cycle.
module tb_a2d_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        cnv_cmplt, busy;

  a2d_scheduler #(.SCLK_DIV_W(5)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .cnv_cmplt(cnv_cmplt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Window = 9 clk to first fall + 16 low + 15 periods of 32 + 16 high
  // = 521; conversion = 521 + 2 gap + 521, so DONE is busy cycle 1044.
  localparam int LAT = 1044;

  int total = 0;
  int bad = 0;
  int cmplt_cnt = 0;
  int win_cnt = 0;

  logic [11:0] adc_val [3];
  logic [15:0] cmd_tab [3];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] adc_for(input logic [2:0] c);
    case (c)
      3'd0:    return adc_val[0];
      3'd4:    return adc_val[1];
      3'd5:    return adc_val[2];
      default: return 12'hBAD;
    endcase
  endfunction

  // conversion model: fixed latency, result taken from the ADC table
  logic       m_busy, m_cmplt;
  int         m_cnt;
  logic [1:0] m_ptr;
  logic [11:0] m_res [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cmplt <= 1'b0;
      m_cnt <= 0;
      m_ptr <= 2'd0;
      m_res[0] <= 12'h000;
      m_res[1] <= 12'h000;
      m_res[2] <= 12'h000;
    end else if (!m_busy) begin
      if (nxt) begin
        m_busy <= 1'b1;
        m_cnt <= 0;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1) begin
        m_cmplt <= 1'b1;
        m_res[m_ptr] <= adc_val[m_ptr];
        m_ptr <= (m_ptr == 2'd2) ? 2'd0 : m_ptr + 2'd1;
      end
      if (m_cnt == LAT) begin
        m_cmplt <= 1'b0;
        m_busy <= 1'b0;
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy", busy, m_busy);
        chk("cnv_cmplt", cnv_cmplt, m_cmplt);
        chk("lft_ld", lft_ld, m_res[0]);
        chk("rght_ld", rght_ld, m_res[1]);
        chk("batt", batt, m_res[2]);
        if (!m_busy)
          chk("idle_pins", {SS_n, SCLK, MOSI}, 3'b110);
        if (cnv_cmplt)
          cmplt_cnt++;
      end
    end
  end

  // ADC128S model plus SPI timing monitor
  int          cyc = 0;
  int          falls, rises, last_rise, gap_t;
  logic        p_ss, p_sclk, p_mosi, after_rise, rise_mosi, win;
  logic [15:0] word, miso_word;
  logic [2:0]  chan;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        win = 1'b0;
        p_ss = 1'b1;
        p_sclk = 1'b1;
        p_mosi = 1'b0;
        after_rise = 1'b0;
        gap_t = 0;
        falls = 0;
        rises = 0;
        chan = 3'd0;
        MISO = 1'b0;
      end else begin
        if (after_rise) begin
          chk("mosi_hold", MOSI, rise_mosi);
          after_rise = 1'b0;
        end
        if (p_ss && !SS_n) begin
          falls = 0;
          rises = 0;
          last_rise = -1;
          word = 16'h0000;
          if (win)
            chk("gap_len", cyc - gap_t, 2);
        end
        if (!SS_n) begin
          if (p_sclk && !SCLK && falls < 16) begin
            falls++;
            miso_word = win ? {4'h0, adc_for(chan)} : 16'h5A5A;
            MISO = miso_word[16 - falls];
          end
          if (!p_sclk && SCLK) begin
            rises++;
            chk("mosi_setup", MOSI, p_mosi);
            word = {word[14:0], MOSI};
            if (last_rise >= 0)
              chk("sclk_period", cyc - last_rise, 32);
            last_rise = cyc;
            after_rise = 1'b1;
            rise_mosi = MOSI;
          end
        end
        if (!p_ss && SS_n) begin
          chk("falls", falls, 16);
          chk("rises", rises, 16);
          chk("sclk_at_ss_rise", SCLK, 1'b1);
          if (!win) begin
            chk("cmd_word", word, cmd_tab[m_ptr]);
            chan = word[13:11];
            gap_t = cyc;
            win = 1'b1;
          end else begin
            chk("read_word", word, 16'h0000);
            win = 1'b0;
          end
          win_cnt++;
          MISO = 1'b0;
        end
        p_ss = SS_n;
        p_sclk = SCLK;
        p_mosi = MOSI;
      end
      cyc++;
    end
  end

  task automatic wait_cmplt(output int lat);
    lat = 0;
    while (!cnv_cmplt && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!cnv_cmplt)
      chk("cmplt_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic do_conv(output int lat);
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    wait_cmplt(lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int lat, c0, w0;

  initial begin
    cmd_tab[0] = 16'h0000;
    cmd_tab[1] = 16'h2000;
    cmd_tab[2] = 16'h2800;
    adc_val[0] = 12'h000;
    adc_val[1] = 12'h000;
    adc_val[2] = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_pins", {SS_n, SCLK, MOSI}, 3'b110);
    chk("rst_regs", {lft_ld, rght_ld, batt}, 36'h0);
    chk("rst_flags", {busy, cnv_cmplt}, 2'b00);
    rst = 1'b0;

    // single conversion on channel 0
    adc_val[0] = 12'h123;
    c0 = cmplt_cnt;
    w0 = win_cnt;
    do_conv(lat);
    chk("lat_first", lat, LAT);
    chk("lft_123", lft_ld, 12'h123);
    chk("one_pulse", cmplt_cnt - c0, 1);
    chk("two_windows", win_cnt - w0, 2);

    // round robin 0 -> 4 -> 5
    do_reset();
    adc_val[0] = 12'hA5A;
    adc_val[1] = 12'h3C3;
    adc_val[2] = 12'hBEE;
    for (int i = 0; i < 3; i++) begin
      do_conv(lat);
      chk("lat_const", lat, LAT);
    end
    chk("rr_lft", lft_ld, 12'hA5A);
    chk("rr_rght", rght_ld, 12'h3C3);
    chk("rr_batt", batt, 12'hBEE);

    // wrap back to channel 0
    adc_val[0] = 12'h777;
    do_conv(lat);
    chk("wrap_lft", lft_ld, 12'h777);
    chk("wrap_rght", rght_ld, 12'h3C3);
    chk("wrap_batt", batt, 12'hBEE);

    // extra requests while busy are dropped
    adc_val[1] = 12'h456;
    adc_val[2] = 12'h0F1;
    c0 = cmplt_cnt;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (97) @(negedge clk);
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
    end
    wait_cmplt(lat);
    repeat (20) @(negedge clk);
    chk("busy_one_pulse", cmplt_cnt - c0, 1);
    chk("busy_rght", rght_ld, 12'h456);
    do_conv(lat);
    chk("busy_next_batt", batt, 12'h0F1);

    // asynchronous reset in the middle of the read transaction
    adc_val[0] = 12'h999;
    c0 = cmplt_cnt;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (700) @(negedge clk);
    chk("mid_read_ss", SS_n, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_pins", {SS_n, SCLK, MOSI}, 3'b110);
    chk("async_regs", {lft_ld, rght_ld, batt}, 36'h0);
    chk("async_flags", {busy, cnv_cmplt}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_no_pulse", cmplt_cnt - c0, 0);
    adc_val[0] = 12'h5E1;
    do_conv(lat);
    chk("post_rst_lat", lat, LAT);
    chk("post_rst_lft", lft_ld, 12'h5E1);
    chk("post_rst_rght", rght_ld, 12'h000);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
